// File: rtl/wb_regfile_pkg.sv
// Shared CPU definitions used by the writeback stage: register index width
// and the RV32I load size/sign encodings.
package wb_regfile_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_e;

endpackage

// File: rtl/wb_regfile_load_ext.sv
// Load data extension: turns bit-0-aligned load data into a full-width
// writeback value according to the load funct3 code.
module load_ext
   import wb_regfile_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] ext
);

   // Unknown codes pass the word through untouched, same as LW.
   always_comb begin
      ext = data;
      case (funct3)
         LB:      ext = {{(WIDTH-8){data[7]}}, data[7:0]};
         LH:      ext = {{(WIDTH-16){data[15]}}, data[15:0]};
         LBU:     ext = {{(WIDTH-8){1'b0}}, data[7:0]};
         LHU:     ext = {{(WIDTH-16){1'b0}}, data[15:0]};
         default: ext = data;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage with register file: selects/extends the writeback value,
// writes it into storage, bypasses it to the read ports, and counts retires.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREGS = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   input  logic [WIDTH-1:0]      mem_data_in,
   input  logic [WIDTH-1:0]      alu_result_in,
   input  logic [REG_ADDR_W-1:0] dest_reg_in,
   input  logic                  reg_write_en_in,
   input  logic                  mem_to_reg_in,
   input  logic [2:0]            load_funct3_in,
   input  logic [REG_ADDR_W-1:0] rs1_addr_in,
   input  logic [REG_ADDR_W-1:0] rs2_addr_in,
   output logic [WIDTH-1:0]      rs1_data_out,
   output logic [WIDTH-1:0]      rs2_data_out,
   output logic [WIDTH-1:0]      wb_data_out,
   output logic [63:0]           instret_out
);

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] load_data;
   logic [63:0]      instret_q;
   logic             we;

   load_ext #(.WIDTH(WIDTH)) u_load_ext (
      .funct3 (load_funct3_in),
      .data   (mem_data_in),
      .ext    (load_data)
   );

   assign wb_data_out = mem_to_reg_in ? load_data : alu_result_in;

   // rst_n is folded in so that reset also disables the bypass path.
   assign we = rst_n & valid_in & reg_write_en_in & (dest_reg_in != '0);

   always_comb begin
      rs1_data_out = regs[rs1_addr_in];
      if (rs1_addr_in == '0)
         rs1_data_out = '0;
      else if (we && (rs1_addr_in == dest_reg_in))
         rs1_data_out = wb_data_out;
   end

   always_comb begin
      rs2_data_out = regs[rs2_addr_in];
      if (rs2_addr_in == '0)
         rs2_data_out = '0;
      else if (we && (rs2_addr_in == dest_reg_in))
         rs2_data_out = wb_data_out;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
         instret_q <= '0;
      end else begin
         if (we)
            regs[dest_reg_in] <= wb_data_out;
         if (valid_in)
            instret_q <= instret_q + 64'd1;
      end
   end

   assign instret_out = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

   logic        clk;
   logic        rst_n;
   logic        valid_in;
   logic [31:0] mem_data_in;
   logic [31:0] alu_result_in;
   logic [4:0]  dest_reg_in;
   logic        reg_write_en_in;
   logic        mem_to_reg_in;
   logic [2:0]  load_funct3_in;
   logic [4:0]  rs1_addr_in;
   logic [4:0]  rs2_addr_in;
   logic [31:0] rs1_data_out;
   logic [31:0] rs2_data_out;
   logic [31:0] wb_data_out;
   logic [63:0] instret_out;

   int          asserts;
   int          failures;
   logic [63:0] expInstret;

   wb_regfile #(.WIDTH(32), .NREGS(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .valid_in        (valid_in),
      .mem_data_in     (mem_data_in),
      .alu_result_in   (alu_result_in),
      .dest_reg_in     (dest_reg_in),
      .reg_write_en_in (reg_write_en_in),
      .mem_to_reg_in   (mem_to_reg_in),
      .load_funct3_in  (load_funct3_in),
      .rs1_addr_in     (rs1_addr_in),
      .rs2_addr_in     (rs2_addr_in),
      .rs1_data_out    (rs1_data_out),
      .rs2_data_out    (rs2_data_out),
      .wb_data_out     (wb_data_out),
      .instret_out     (instret_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic rst, input logic vld, input logic wen,
                                input logic m2r, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [31:0] alu, input logic [31:0] mem,
                                input logic [4:0] ra, input logic [4:0] rb);
      rst_n           = rst;
      valid_in        = vld;
      reg_write_en_in = wen;
      mem_to_reg_in   = m2r;
      load_funct3_in  = f3;
      dest_reg_in     = rd;
      alu_result_in   = alu;
      mem_data_in     = mem;
      rs1_addr_in     = ra;
      rs2_addr_in     = rb;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      asserts++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance one clock, updating the expected retire count first.
   task automatic tick();
      if (rst_n !== 1'b1)
         expInstret = 64'd0;
      else if (valid_in === 1'b1)
         expInstret = expInstret + 64'd1;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      asserts    = 0;
      failures   = 0;
      expInstret = 64'd0;

      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      tick();

      // Fill a few registers so the second reset has something to clear.
      for (int i = 1; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'(i), 32'hA0A0_0000 + 32'(i),
                       32'd0, 5'd0, 5'd0);
         tick();
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'd0, 32'd0, 5'd2, 5'd4);
      checkOutput("prefill_x2", {32'd0, rs1_data_out}, 64'hA0A0_0002);
      checkOutput("prefill_x4", {32'd0, rs2_data_out}, 64'hA0A0_0004);
      checkOutput("prefill_instret", instret_out, 64'd4);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      for (int i = 0; i < 32; i++) begin
         rs1_addr_in = 5'(i);
         rs2_addr_in = 5'(31 - i);
         #1;
         checkOutput($sformatf("reset_rs1_x%0d", i), {32'd0, rs1_data_out}, 64'd0);
         checkOutput($sformatf("reset_rs2_x%0d", 31 - i), {32'd0, rs2_data_out}, 64'd0);
      end
      checkOutput("reset_instret", instret_out, 64'd0);

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd5, 32'hDEAD_BEEF, 32'h1111_1111,
                    5'd5, 5'd6);
      checkOutput("bypass_rs1_x5", {32'd0, rs1_data_out}, 64'hDEAD_BEEF);
      checkOutput("nobypass_rs2_x6", {32'd0, rs2_data_out}, 64'd0);
      checkOutput("wb_alu", {32'd0, wb_data_out}, 64'hDEAD_BEEF);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'd0, 32'd0, 5'd5, 5'd5);
      checkOutput("stored_rs1_x5", {32'd0, rs1_data_out}, 64'hDEAD_BEEF);
      checkOutput("stored_rs2_x5", {32'd0, rs2_data_out}, 64'hDEAD_BEEF);
      checkOutput("instret_after_write", instret_out, expInstret);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 5'd0, 32'h1234_5678, 32'h0000_80F0,
                    5'd0, 5'd0);
      checkOutput("lb_ext", {32'd0, wb_data_out}, 64'hFFFF_FFF0);
      load_funct3_in = 3'b100; #1;
      checkOutput("lbu_ext", {32'd0, wb_data_out}, 64'h0000_00F0);
      load_funct3_in = 3'b001; #1;
      checkOutput("lh_ext", {32'd0, wb_data_out}, 64'hFFFF_80F0);
      load_funct3_in = 3'b101; #1;
      checkOutput("lhu_ext", {32'd0, wb_data_out}, 64'h0000_80F0);
      mem_data_in = 32'h8765_4321; load_funct3_in = 3'b010; #1;
      checkOutput("lw_word", {32'd0, wb_data_out}, 64'h8765_4321);
      load_funct3_in = 3'b111; #1;
      checkOutput("other_code_word", {32'd0, wb_data_out}, 64'h8765_4321);
      mem_data_in = 32'h0000_0070; load_funct3_in = 3'b000; #1;
      checkOutput("lb_positive", {32'd0, wb_data_out}, 64'h0000_0070);
      mem_to_reg_in = 1'b0; #1;
      checkOutput("alu_select", {32'd0, wb_data_out}, 64'h1234_5678);

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 5'd8, 32'h0, 32'h0000_80F0, 5'd8, 5'd0);
      checkOutput("load_bypass_x8", {32'd0, rs1_data_out}, 64'hFFFF_FFF0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'd0, 32'd0, 5'd8, 5'd0);
      checkOutput("load_stored_x8", {32'd0, rs1_data_out}, 64'hFFFF_FFF0);

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd0, 32'h1234_5678, 32'd0, 5'd0, 5'd0);
      checkOutput("x0_rs1_same", {32'd0, rs1_data_out}, 64'd0);
      checkOutput("x0_rs2_same", {32'd0, rs2_data_out}, 64'd0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      checkOutput("x0_rs1_next", {32'd0, rs1_data_out}, 64'd0);
      checkOutput("x0_rs2_next", {32'd0, rs2_data_out}, 64'd0);
      checkOutput("instret_x0_counts", instret_out, expInstret);

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd7, 32'h0000_0077, 32'd0, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 5'd7, 32'h0000_0055, 32'd0, 5'd7, 5'd7);
      checkOutput("bubble_no_bypass", {32'd0, rs1_data_out}, 64'h0000_0077);
      tick();
      checkOutput("bubble_x7_kept", {32'd0, rs2_data_out}, 64'h0000_0077);
      checkOutput("bubble_instret", instret_out, expInstret);

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd9, 32'hC0DE_0009, 32'd0, 5'd9, 5'd9);
      checkOutput("dual_bypass_rs1", {32'd0, rs1_data_out}, 64'hC0DE_0009);
      checkOutput("dual_bypass_rs2", {32'd0, rs2_data_out}, 64'hC0DE_0009);
      tick();

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      #1;
      expInstret = 64'hFFFF_FFFF_FFFF_FFFF;
      checkOutput("instret_preload", instret_out, expInstret);
      valid_in = 1'b1; #1;
      tick();
      checkOutput("instret_wrap", instret_out, 64'd0);

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd3, 32'h3333_3333, 32'd0, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 5'd3, 32'hCAFE_F00D, 32'd0, 5'd3, 5'd0);
      checkOutput("reset_no_bypass_x3", {32'd0, rs1_data_out}, 64'h3333_3333);
      checkOutput("reset_wb_comb", {32'd0, wb_data_out}, 64'hCAFE_F00D);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'd0, 32'd0, 5'd3, 5'd9);
      checkOutput("reset_prio_x3", {32'd0, rs1_data_out}, 64'd0);
      checkOutput("reset_prio_x9", {32'd0, rs2_data_out}, 64'd0);
      checkOutput("reset_prio_instret", instret_out, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of register file and writeback data.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count (address width 5).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 valid_in  input  1  MEM/WB slot holds a real instruction (0 = bubble).
REQ-006 mem_data_in  input  WIDTH  load data from MEM/WB, byte/half already aligned to bit 0.
REQ-007 alu_result_in  input  WIDTH  ALU result from MEM/WB.
REQ-008 dest_reg_in  input  5  destination register index.
REQ-009 reg_write_en_in  input  1  instruction writes rd.
REQ-010 mem_to_reg_in  input  1  1 = writeback from load data, 0 = from ALU result.
REQ-011 load_funct3_in  input  3  load size/sign code (RV32I funct3).
REQ-012 rs1_addr_in, rs2_addr_in  input  5 each  ID-stage read addresses.
REQ-013 rs1_data_out, rs2_data_out  output  WIDTH each  read data, combinational.
REQ-014 wb_data_out  output  WIDTH  selected and extended writeback value, combinational.
REQ-015 instret_out  output  64  retired-instruction count, registered.

Function
REQ-016 Load extension SHALL apply when mem_to_reg_in=1: 000 sign-extend bits[7:0]; 001 sign-extend [15:0]; 010 full word; 100 zero-extend [7:0]; 101 zero-extend [15:0]; any other code full word.
REQ-017 wb_data_out SHALL equal the extended load data when mem_to_reg_in=1, else alu_result_in.
REQ-018 Write condition we = rst_n & valid_in & reg_write_en_in & (dest_reg_in != 0); at posedge with we=1, register[dest_reg_in] SHALL take wb_data_out.
REQ-019 Register 0 SHALL never be written and SHALL always read 0.
REQ-020 Read ports SHALL bypass: if we=1 and rsN_addr_in == dest_reg_in != 0, rsN_data_out SHALL equal wb_data_out in the same cycle (write-before-read, zero added latency).
REQ-021 Otherwise rsN_data_out SHALL equal stored register contents; both ports independent, both may hit the same address.
REQ-022 valid_in=0 SHALL suppress writes regardless of reg_write_en_in and SHALL suppress bypass.
REQ-023 instret_out SHALL increment by 1 at each posedge with rst_n=1 and valid_in=1; wraps from 2^64-1 to 0.
REQ-024 Write latency: value visible from storage on the cycle after write; via bypass in the write cycle.

Reset
REQ-025 rst_n=0 sampled at posedge SHALL clear all registers 1..NREGS-1 to 0 and instret_out to 0.
REQ-026 Reset SHALL take priority over a simultaneous write or count; the in-flight write is discarded.
REQ-027 During reset, read ports and wb_data_out remain combinational; bypass disabled (we=0).

Structure
REQ-028 Load funct3 encodings (LB, LH, LW, LBU, LHU) and register-index width SHALL live in the shared CPU package.
REQ-029 Load extension SHALL be one combinational sub-module, load_ext; storage, bypass and counter stay in wb_regfile.

Verification
REQ-030 Reset: rst_n=0 one cycle -> all 32 reads return 0, instret_out=0.
REQ-031 Write/read: valid, we, rd=5, ALU=0xDEADBEEF, rs1=5 same cycle -> rs1_data_out=0xDEADBEEF (bypass), next cycle still 0xDEADBEEF from storage.
REQ-032 Load ext: mem_data_in=0x000080F0, funct3=000 -> wb=0xFFFFFFF0; 100 -> 0x000000F0; 001 -> 0xFFFF80F0; 101 -> 0x000080F0.
REQ-033 x0: write rd=0 data 0x12345678 -> rs1=0, rs2=0 read 0 same and next cycle.
REQ-034 Bubble: valid_in=0, we=1, rd=7, data 0x55 -> x7 unchanged, instret_out unchanged.
REQ-035 Counter/reset priority: preload instret=2^64-1, valid -> 0; assert rst_n=0 with valid write to x3 -> x3=0, instret=0.
